// File: rtl/cam_pwr_seq.sv
// rtl/cam_pwr_seq.sv - camera sensor power-up / reset / config sequencer
//
// Purpose:
//   Walks the sensor through power-down hold, reset hold and settle phases,
//   issues a single-cycle config request and then waits for the config
//   engine. A single shared down-counter is reloaded on entry to each timed
//   phase. All outputs are registered and decoded from the next state, so
//   there is no combinational path from any input to any output.
//
// Optional feature:
//   CAM_SEQ_TIMEOUT_EN - when defined, CFG_WAIT is bounded by cfg_timeout_g
//   cycles and expires into ERR. When undefined, CFG_WAIT waits forever and
//   error_o is tied to 0.
//
// Ports:
//   clk_i        in   system clock, rising edge
//   rst_i        in   synchronous reset, active-high
//   start_i      in   start/retry request, honoured in IDLE, READY and ERR
//   cfg_done_i   in   config engine finished, honoured in CFG_WAIT only
//   cam_pwdn_o   out  sensor power-down (1 = powered down)
//   cam_rst_n_o  out  sensor reset, active-low
//   cfg_start_o  out  one-cycle config request pulse
//   busy_o       out  sequence in progress
//   ready_o      out  sensor powered, out of reset and configured
//   error_o      out  config timeout
module cam_pwr_seq #(
  parameter int pwdn_cycles_g   = 4,
  parameter int rst_cycles_g    = 3,
  parameter int settle_cycles_g = 5,
  parameter int cfg_timeout_g   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic cfg_done_i,
  output logic cam_pwdn_o,
  output logic cam_rst_n_o,
  output logic cfg_start_o,
  output logic busy_o,
  output logic ready_o,
  output logic error_o
);

  localparam int max_ab_c  = (pwdn_cycles_g > rst_cycles_g) ? pwdn_cycles_g : rst_cycles_g;
  localparam int max_cd_c  = (settle_cycles_g > cfg_timeout_g) ? settle_cycles_g : cfg_timeout_g;
  localparam int max_c     = (max_ab_c > max_cd_c) ? max_ab_c : max_cd_c;
  localparam int cnt_w_c   = $clog2(max_c + 1);

  typedef logic [cnt_w_c-1:0] cnt_t;

  // Each phase loads (length - 1) so that the phase lasts exactly its length.
  localparam cnt_t pwdn_load_c   = cnt_t'(pwdn_cycles_g - 1);
  localparam cnt_t rst_load_c    = cnt_t'(rst_cycles_g - 1);
  localparam cnt_t settle_load_c = cnt_t'(settle_cycles_g - 1);
  localparam cnt_t cfg_load_c    = cnt_t'(cfg_timeout_g - 1);
  localparam cnt_t one_c         = cnt_t'(1);

  if (pwdn_cycles_g < 1) begin : g_bad_pwdn
    $error("cam_pwr_seq: pwdn_cycles_g must be >= 1");
  end
  if (rst_cycles_g < 1) begin : g_bad_rst
    $error("cam_pwr_seq: rst_cycles_g must be >= 1");
  end
  if (settle_cycles_g < 1) begin : g_bad_settle
    $error("cam_pwr_seq: settle_cycles_g must be >= 1");
  end
  if (cfg_timeout_g < 1) begin : g_bad_timeout
    $error("cam_pwr_seq: cfg_timeout_g must be >= 1");
  end

  typedef enum logic [2:0] {
    st_idle,
    st_pwdn_hold,
    st_rst_hold,
    st_settle,
    st_cfg_req,
    st_cfg_wait,
    st_ready,
    st_err
  } state_t;

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;

  logic pwdn_d, rst_n_d, cfg_start_d, busy_d, ready_d, error_d;

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      st_idle, st_ready, st_err: begin
        if (start_i) begin
          state_d = st_pwdn_hold;
          cnt_d   = pwdn_load_c;
        end
      end
      st_pwdn_hold: begin
        if (cnt_q == '0) begin
          state_d = st_rst_hold;
          cnt_d   = rst_load_c;
        end else begin
          cnt_d = cnt_q - one_c;
        end
      end
      st_rst_hold: begin
        if (cnt_q == '0) begin
          state_d = st_settle;
          cnt_d   = settle_load_c;
        end else begin
          cnt_d = cnt_q - one_c;
        end
      end
      st_settle: begin
        if (cnt_q == '0) begin
          state_d = st_cfg_req;
        end else begin
          cnt_d = cnt_q - one_c;
        end
      end
      st_cfg_req: begin
        state_d = st_cfg_wait;
        cnt_d   = cfg_load_c;
      end
      st_cfg_wait: begin
        // cfg_done_i takes priority over an expiring timeout in the same cycle.
        if (cfg_done_i) begin
          state_d = st_ready;
        end
`ifdef CAM_SEQ_TIMEOUT_EN
        else if (cnt_q == '0) begin
          state_d = st_err;
        end else begin
          cnt_d = cnt_q - one_c;
        end
`endif
      end
      default: begin
        state_d = st_idle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the state being entered; registered below so the
  // pins change on the same edge as the state.
  always_comb begin
    pwdn_d      = 1'b1;
    rst_n_d     = 1'b0;
    cfg_start_d = 1'b0;
    busy_d      = 1'b0;
    ready_d     = 1'b0;
    error_d     = 1'b0;
    case (state_d)
      st_pwdn_hold: begin
        busy_d = 1'b1;
      end
      st_rst_hold: begin
        pwdn_d = 1'b0;
        busy_d = 1'b1;
      end
      st_settle, st_cfg_wait: begin
        pwdn_d  = 1'b0;
        rst_n_d = 1'b1;
        busy_d  = 1'b1;
      end
      st_cfg_req: begin
        pwdn_d      = 1'b0;
        rst_n_d     = 1'b1;
        cfg_start_d = 1'b1;
        busy_d      = 1'b1;
      end
      st_ready: begin
        pwdn_d  = 1'b0;
        rst_n_d = 1'b1;
        ready_d = 1'b1;
      end
      st_err: begin
        error_d = 1'b1;
      end
      default: begin
        pwdn_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= st_idle;
      cnt_q       <= '0;
      cam_pwdn_o  <= 1'b1;
      cam_rst_n_o <= 1'b0;
      cfg_start_o <= 1'b0;
      busy_o      <= 1'b0;
      ready_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cam_pwdn_o  <= pwdn_d;
      cam_rst_n_o <= rst_n_d;
      cfg_start_o <= cfg_start_d;
      busy_o      <= busy_d;
      ready_o     <= ready_d;
    end
  end

`ifdef CAM_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      error_o <= 1'b0;
    end else begin
      error_o <= error_d;
    end
  end
`else
  // ERR is unreachable without the timeout, so the error flag is a constant.
  logic unused_error;
  assign unused_error = error_d;
  assign error_o      = 1'b0;
`endif

endmodule

// File: tb/tb_cam_pwr_seq.sv
// tb/tb_cam_pwr_seq.sv - scoreboard bench for cam_pwr_seq
module tb_cam_pwr_seq;

  logic clk_i = 1'b0;
  logic rst_i;
  logic start_i;
  logic cfg_done_i;
  logic cam_pwdn_o, cam_rst_n_o, cfg_start_o, busy_o, ready_o, error_o;

  cam_pwr_seq #(
    .pwdn_cycles_g  (4),
    .rst_cycles_g   (3),
    .settle_cycles_g(5),
    .cfg_timeout_g  (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .cfg_done_i (cfg_done_i),
    .cam_pwdn_o (cam_pwdn_o),
    .cam_rst_n_o(cam_rst_n_o),
    .cfg_start_o(cfg_start_o),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .error_o    (error_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [5:0] v_idle = 6'b100000;
  localparam logic [5:0] v_pw   = 6'b100100;
  localparam logic [5:0] v_rh   = 6'b000100;
  localparam logic [5:0] v_st   = 6'b010100;
  localparam logic [5:0] v_cq   = 6'b011100;
  localparam logic [5:0] v_cw   = 6'b010100;
  localparam logic [5:0] v_rd   = 6'b010010;
  localparam logic [5:0] v_er   = 6'b100001;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    logic [5:0] act;
    act = {cam_pwdn_o, cam_rst_n_o, cfg_start_o, busy_o, ready_o, error_o};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_chk++;
      $display("FAIL %s cyc=%0d missed expectation want=%b", sb[0].tag, sb[0].cyc, sb[0].vec);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      n_chk++;
      if (act === sb[0].vec) n_pass++;
      else $display("FAIL %s cyc=%0d got=%b want=%b", sb[0].tag, cyc, act, sb[0].vec);
      void'(sb.pop_front());
    end
  end

  task automatic push_range(input int base, input int from, input int to,
                            input logic [5:0] v, input string tag);
    for (int k = from; k <= to; k++) begin
      exp_t e;
      e.cyc = base + k;
      e.vec = v;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic push_seq(input int base, input int last, input string tag);
    push_range(base, 1, 4, v_pw, {tag, "_pwdn"});
    push_range(base, 5, 7, v_rh, {tag, "_rsthold"});
    push_range(base, 8, 12, v_st, {tag, "_settle"});
    push_range(base, 13, 13, v_cq, {tag, "_cfgreq"});
    push_range(base, 14, last, v_cw, {tag, "_cfgwait"});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk_i);
  endtask

  initial begin
    int c;
    rst_i      = 1'b1;
    start_i    = 1'b0;
    cfg_done_i = 1'b0;
    @(negedge clk_i);

    c = cyc;
    push_range(c, 1, 3, v_idle, "t1_reset");
    wait_cyc(c + 2); rst_i = 1'b0;
    wait_cyc(c + 3);
    n_chk++;
    if (busy_o === 1'b0) n_pass++;
    else $display("FAIL t1_direct_busy got=%b", busy_o);
    n_chk++;
    if (error_o === 1'b0) n_pass++;
    else $display("FAIL t1_direct_error got=%b", error_o);
    n_chk++;
    if (cam_pwdn_o === 1'b1) n_pass++;
    else $display("FAIL t1_direct_pwdn got=%b", cam_pwdn_o);

    c = cyc;
    push_seq(c, 16, "t2");
    push_range(c, 17, 19, v_rd, "t2_ready");
    start_i = 1'b1;
    wait_cyc(c + 1);  start_i = 1'b0;
    wait_cyc(c + 13);
    n_chk++;
    if (cfg_start_o === 1'b1) n_pass++;
    else $display("FAIL t2_direct_cfgstart got=%b", cfg_start_o);
    wait_cyc(c + 16); cfg_done_i = 1'b1;
    wait_cyc(c + 17); cfg_done_i = 1'b0;
    wait_cyc(c + 19);
    n_chk++;
    if (ready_o === 1'b1) n_pass++;
    else $display("FAIL t2_direct_ready got=%b", ready_o);
    n_chk++;
    if (busy_o === 1'b0) n_pass++;
    else $display("FAIL t2_direct_busy got=%b", busy_o);

    c = cyc;
    push_seq(c, 16, "t3");
    push_range(c, 17, 19, v_rd, "t3_ready");
    start_i = 1'b1;
    wait_cyc(c + 1);  start_i = 1'b0;
    wait_cyc(c + 3);  start_i = 1'b1;
    wait_cyc(c + 4);  start_i = 1'b0;
    wait_cyc(c + 9);  start_i = 1'b1;
    wait_cyc(c + 10); start_i = 1'b0;
    wait_cyc(c + 13); cfg_done_i = 1'b1;
    wait_cyc(c + 14); cfg_done_i = 1'b0; start_i = 1'b1;
    wait_cyc(c + 15); start_i = 1'b0;
    wait_cyc(c + 16); cfg_done_i = 1'b1;
    wait_cyc(c + 17); cfg_done_i = 1'b0;
    wait_cyc(c + 19);

    c = cyc;
    push_seq(c, 21, "t4");
`ifdef CAM_SEQ_TIMEOUT_EN
    push_range(c, 22, 24, v_er, "t4_error");
    start_i = 1'b1;
    wait_cyc(c + 1);  start_i = 1'b0;
    wait_cyc(c + 24);
`else
    push_range(c, 22, 24, v_cw, "t4_stillwait");
    push_range(c, 100, 100, v_cw, "t4_wait100");
    push_range(c, 101, 101, v_rd, "t4_lateready");
    start_i = 1'b1;
    wait_cyc(c + 1);   start_i = 1'b0;
    wait_cyc(c + 100); cfg_done_i = 1'b1;
    wait_cyc(c + 101); cfg_done_i = 1'b0;
`endif

    c = cyc;
    push_seq(c, 21, "t5");
    push_range(c, 22, 23, v_rd, "t5_ready");
    start_i = 1'b1;
    wait_cyc(c + 1);  start_i = 1'b0;
    wait_cyc(c + 21); cfg_done_i = 1'b1;
    wait_cyc(c + 22); cfg_done_i = 1'b0;
    wait_cyc(c + 23);

    c = cyc;
    push_range(c, 1, 4, v_pw, "t6_pwdn");
    push_range(c, 5, 7, v_rh, "t6_rsthold");
    push_range(c, 8, 10, v_st, "t6_settle");
    push_range(c, 11, 12, v_idle, "t6_reset");
    push_seq(c + 12, 14, "t6b");
    push_range(c, 27, 28, v_rd, "t6b_ready");
    start_i = 1'b1;
    wait_cyc(c + 1);  start_i = 1'b0;
    wait_cyc(c + 10); rst_i = 1'b1;
    wait_cyc(c + 11); rst_i = 1'b0;
    wait_cyc(c + 12); start_i = 1'b1;
    wait_cyc(c + 13); start_i = 1'b0;
    wait_cyc(c + 26); cfg_done_i = 1'b1;
    wait_cyc(c + 27); cfg_done_i = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk_i);
    while (sb.size() > 0) begin
      n_chk++;
      $display("FAIL %s cyc=%0d never checked want=%b", sb[0].tag, sb[0].cyc, sb[0].vec);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    if (n_pass == n_chk) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
